// File: rtl/bus_scheduler_pkg.sv
// bus_scheduler_pkg
// Shared definitions for the operand bus: op encodings (also used by the
// accumulator processors), scheduler FSM states and the default data width.
package bus_scheduler_pkg;

    localparam int DW_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_FETCH = 2'b01,
        OP_SEND  = 2'b10
    } op_e;

    typedef enum logic [1:0] {
        ST_ARB     = 2'b00,
        ST_WAIT_OP = 2'b01,
        ST_SIG     = 2'b10,
        ST_RELEASE = 2'b11
    } state_e;

    // Anything other than a clean FETCH or SEND code (including 11, X, Z)
    // is treated as NOP.
    function automatic op_e decode_op(input logic [1:0] raw);
        case (raw)
            2'b01:   decode_op = OP_FETCH;
            2'b10:   decode_op = OP_SEND;
            default: decode_op = OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/bus_scheduler_rr_arbiter.sv
// bus_scheduler_rr_arbiter
// Combinational round-robin pick: searches i_req starting one past
// i_last_owner, wrapping, and returns the first asserted requester.
// Ports:
//   i_req          per-processor request
//   i_last_owner   index of the previous bus owner (lowest priority)
//   o_onehot       one-hot pick (all zero when nobody requests)
//   o_idx          index of the pick
//   o_valid        at least one request present
module bus_scheduler_rr_arbiter #(
    parameter int N_PROC = 4,
    parameter int OW     = 2
) (
    input  logic [N_PROC-1:0] i_req,
    input  logic [OW-1:0]     i_last_owner,
    output logic [N_PROC-1:0] o_onehot,
    output logic [OW-1:0]     o_idx,
    output logic              o_valid
);

    logic [OW-1:0] w_cand;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        w_cand   = '0;
        for (int k = 1; k <= N_PROC; k++) begin
            w_cand = OW'((int'(i_last_owner) + k) % N_PROC);
            if (!o_valid && i_req[w_cand]) begin
                o_valid          = 1'b1;
                o_idx            = w_cand;
                o_onehot[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_scheduler.sv
// bus_scheduler
// Owns the shared operand/result bus of N_PROC accumulator processors and
// keeps the operand pool in a circular buffer. Bus grants are round-robin;
// FETCH pops an operand onto o_read, SEND pushes i_write back into the pool.
// Reduction is done when one operand remains and no processor holds any.
// Ports:
//   clk, reset                 clock, async active-high reset
//   i_req / o_grant            per-processor request, registered one-hot grant
//   i_op                       shared op from the granted processor
//   o_signal                   one-cycle transaction-complete strobe
//   o_read / i_write           operand out, result in
//   i_load_valid/_data, o_load_ready   host operand loading
//   i_start, o_busy, o_done, o_result  run control and final value
//   o_count                    operands in pool
//   o_starved                  sticky: FETCH stalled on empty pool too long
module bus_scheduler
    import bus_scheduler_pkg::*;
#(
    parameter int N_PROC    = 4,
    parameter int DW        = DW_DEFAULT,
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int STALL_MAX = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_PROC-1:0] i_req,
    output logic [N_PROC-1:0] o_grant,
    input  logic [1:0]        i_op,
    output logic              o_signal,
    output logic [DW-1:0]     o_read,
    input  logic [DW-1:0]     i_write,
    input  logic              i_load_valid,
    input  logic [DW-1:0]     i_load_data,
    output logic              o_load_ready,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic [DW-1:0]     o_result,
    output logic [AW:0]       o_count,
    output logic              o_starved
);

    localparam int OW = (N_PROC > 1) ? $clog2(N_PROC) : 1;
    localparam int SW = (STALL_MAX > 0) ? $clog2(STALL_MAX + 1) : 1;
    localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
    localparam logic [AW:0]   CNT_TWO    = (AW+1)'(2);
    localparam logic [AW:0]   CNT_FULL   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [OW-1:0] OWNER_RST  = OW'(N_PROC - 1);
    localparam logic [SW-1:0] STALL_LOAD = SW'(STALL_MAX);
    localparam logic [SW-1:0] STALL_ONE  = SW'(1);

    state_e            r_state, w_state_nxt;
    logic [OW-1:0]     r_owner;
    logic [N_PROC-1:0] r_grant;
    logic              r_signal;
    logic [DW-1:0]     r_read;
    logic [DW-1:0]     r_mem [DEPTH];
    logic [AW-1:0]     r_head, r_tail;
    logic [AW:0]       r_count, r_held;
    logic              r_running, r_done, r_starved;
    logic [SW-1:0]     r_stall_tmr;

    logic [N_PROC-1:0] w_arb_onehot;
    logic [OW-1:0]     w_arb_idx;
    logic              w_arb_valid;
    op_e               w_op;
    logic              w_load_ready, w_load, w_start;
    logic              w_take, w_fetch, w_send, w_stall, w_release, w_finish;
    logic              w_mem_we;
    logic [DW-1:0]     w_mem_wdata;

    bus_scheduler_rr_arbiter #(.N_PROC(N_PROC), .OW(OW)) u_arb (
        .i_req        (i_req),
        .i_last_owner (r_owner),
        .o_onehot     (w_arb_onehot),
        .o_idx        (w_arb_idx),
        .o_valid      (w_arb_valid)
    );

    assign w_op         = decode_op(i_op);
    assign w_load_ready = !r_running && (r_count < CNT_FULL);
    assign w_load       = i_load_valid && w_load_ready;
    assign w_start      = i_start && !r_running && (r_count != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_ARB;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_fetch     = 1'b0;
        w_send      = 1'b0;
        w_stall     = 1'b0;
        w_release   = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_ARB: begin
                if (r_running && r_count == CNT_ONE && r_held == '0) begin
                    w_finish = 1'b1;
                end else if (r_running && w_arb_valid) begin
                    w_take      = 1'b1;
                    w_state_nxt = ST_WAIT_OP;
                end
            end
            ST_WAIT_OP: begin
                if (w_op == OP_FETCH) begin
                    if (r_count != '0) begin
                        w_fetch     = 1'b1;
                        w_state_nxt = ST_SIG;
                    end else begin
                        w_stall = 1'b1;
                    end
                end else if (w_op == OP_SEND) begin
                    w_send      = 1'b1;
                    w_state_nxt = ST_SIG;
                end
            end
            ST_SIG: begin
                w_release   = 1'b1;
                w_state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                // Owner must drop req before we re-arbitrate, so it never
                // mistakes the old grant for a new one.
                if (!i_req[r_owner]) w_state_nxt = ST_ARB;
            end
            default: w_state_nxt = ST_ARB;
        endcase
    end

    // Loads only happen while idle and SEND only while running, so the two
    // never compete for the write port.
    assign w_mem_we    = w_load || w_send;
    assign w_mem_wdata = w_send ? i_write : i_load_data;

    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[r_tail] <= w_mem_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant     <= '0;
            r_signal    <= 1'b0;
            r_read      <= '0;
            r_owner     <= OWNER_RST;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_held      <= '0;
            r_running   <= 1'b0;
            r_done      <= 1'b0;
            r_starved   <= 1'b0;
            r_stall_tmr <= '0;
        end else begin
            if (w_mem_we) begin
                r_tail  <= r_tail + PTR_ONE;
                r_count <= r_count + CNT_ONE;
            end
            if (w_fetch) begin
                r_read   <= r_mem[r_head];
                r_head   <= r_head + PTR_ONE;
                r_count  <= r_count - CNT_ONE;
                r_held   <= r_held + CNT_ONE;
                r_signal <= 1'b1;
            end
            if (w_send) begin
                r_held   <= r_held - CNT_TWO;
                r_signal <= 1'b1;
            end
            if (w_take) begin
                r_grant     <= w_arb_onehot;
                r_owner     <= w_arb_idx;
                r_stall_tmr <= STALL_LOAD;
            end
            // Down-counter reaches zero on stall cycle STALL_MAX; the next
            // stall cycle is the one that exceeds the limit.
            if (w_stall) begin
                if (r_stall_tmr == '0) r_starved   <= 1'b1;
                else                   r_stall_tmr <= r_stall_tmr - STALL_ONE;
            end
            if (w_release) begin
                r_grant  <= '0;
                r_signal <= 1'b0;
            end
            if (w_finish) begin
                r_done    <= 1'b1;
                r_running <= 1'b0;
            end
            if (w_start) begin
                r_running <= 1'b1;
                r_done    <= 1'b0;
                r_starved <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_send) begin
            assert (r_count < CNT_FULL);
            assert (r_held >= CNT_TWO);
        end
    end

    assign o_grant      = r_grant;
    assign o_signal     = r_signal;
    assign o_read       = r_read;
    assign o_load_ready = w_load_ready;
    assign o_busy       = r_running;
    assign o_done       = r_done;
    assign o_result     = r_mem[r_head];
    assign o_count      = r_count;
    assign o_starved    = r_starved;

endmodule

// File: tb/tb_bus_scheduler.sv
// tb_bus_scheduler
// Drives two scheduler instances (4 and 2 processors) from shared stimulus;
// outputs of the instance under test are selected by sel2. Operands are
// tracked in a scoreboard queue: loads and SENDs push, FETCH pops/compares.
module tb_bus_scheduler;
    import bus_scheduler_pkg::*;

    localparam int DEPTH = 16;
    localparam int STALL_MAX = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [1:0]  op;
    logic [31:0] wr;
    logic        load_valid;
    logic [31:0] load_data;
    logic        start;
    logic        sel2;

    logic [3:0]  g4;
    logic [1:0]  g2;
    logic        sig4, sig2, lr4, lr2, busy4, busy2, done4, done2, stv4, stv2;
    logic [31:0] rd4, rd2, res4, res2;
    logic [4:0]  cnt4, cnt2;

    logic [3:0]  w_grant;
    logic        w_sig, w_lr, w_busy, w_done, w_starved;
    logic [31:0] w_read, w_result;
    logic [4:0]  w_count;

    int          n_chk = 0;
    int          n_err = 0;
    int          n_sig = 0;
    logic [31:0] sb_q[$];
    bit          m_running;

    always #5 clk = ~clk;

    bus_scheduler #(.N_PROC(4), .DW(32), .DEPTH(DEPTH), .AW(4), .STALL_MAX(STALL_MAX)) dut4 (
        .clk(clk), .reset(reset), .i_req(req), .o_grant(g4), .i_op(op),
        .o_signal(sig4), .o_read(rd4), .i_write(wr), .i_load_valid(load_valid),
        .i_load_data(load_data), .o_load_ready(lr4), .i_start(start), .o_busy(busy4),
        .o_done(done4), .o_result(res4), .o_count(cnt4), .o_starved(stv4)
    );

    bus_scheduler #(.N_PROC(2), .DW(32), .DEPTH(DEPTH), .AW(4), .STALL_MAX(STALL_MAX)) dut2 (
        .clk(clk), .reset(reset), .i_req(req[1:0]), .o_grant(g2), .i_op(op),
        .o_signal(sig2), .o_read(rd2), .i_write(wr), .i_load_valid(load_valid),
        .i_load_data(load_data), .o_load_ready(lr2), .i_start(start), .o_busy(busy2),
        .o_done(done2), .o_result(res2), .o_count(cnt2), .o_starved(stv2)
    );

    always_comb begin
        w_grant   = sel2 ? {2'b00, g2} : g4;
        w_sig     = sel2 ? sig2  : sig4;
        w_lr      = sel2 ? lr2   : lr4;
        w_busy    = sel2 ? busy2 : busy4;
        w_done    = sel2 ? done2 : done4;
        w_starved = sel2 ? stv2  : stv4;
        w_read    = sel2 ? rd2   : rd4;
        w_result  = sel2 ? res2  : res4;
        w_count   = sel2 ? cnt2  : cnt4;
    end

    always @(negedge clk) if (w_sig === 1'b1) n_sig++;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; op = OP_NOP; wr = '0;
        load_valid = 1'b0; load_data = '0; start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sb_q.delete();
        m_running = 1'b0;
        @(negedge clk);
    endtask

    task automatic load_op(input logic [31:0] d);
        load_valid = 1'b1; load_data = d;
        if (!m_running && sb_q.size() < DEPTH) sb_q.push_back(d);
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic start_op();
        start = 1'b1;
        if (!m_running && sb_q.size() >= 1) m_running = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_grant(input int p);
        int n = 0;
        do begin @(negedge clk); n++; end while (!w_grant[p] && n < 20);
    endtask

    // One full bus tenure for processor p. The leading idle cycle keeps req
    // low through RELEASE so back-to-back tenures of one processor are legal.
    task automatic txn(input int p, input logic [1:0] o, input logic [31:0] wd,
                       output logic [31:0] exp_rd);
        logic [3:0] oh;
        int n;
        oh = 4'b0001 << p;
        exp_rd = '0;
        @(negedge clk);
        req[p] = 1'b1;
        wait_grant(p);
        check_val("txn_grant", 32'(w_grant), 32'(oh));
        if (w_grant !== oh) begin req[p] = 1'b0; return; end
        op = o; wr = wd;
        n = 0;
        do begin @(negedge clk); n++; end while (w_sig !== 1'b1 && n < 20);
        check_val("txn_signal", 32'(w_sig), 32'd1);
        check_val("txn_grant_in_sig", 32'(w_grant), 32'(oh));
        if (o == OP_FETCH) begin
            if (sb_q.size() > 0) exp_rd = sb_q.pop_front();
            check_val("txn_read", w_read, exp_rd);
        end else begin
            sb_q.push_back(wd);
        end
        op = OP_NOP; req[p] = 1'b0;
        @(negedge clk);
        check_val("txn_release_grant", 32'(w_grant), 32'd0);
        check_val("txn_sig_pulse", 32'(w_sig), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v, acc [2];
        int          h [2];
        int          nf, ns, sig0, p, q;

        sel2 = 1'b0;
        reset = 1'b1;

        // 1: two-processor reduction of 1,2,3,4
        sel2 = 1'b1;
        do_reset();
        check_val("rst_grant", 32'(w_grant), 32'd0);
        check_val("rst_count", 32'(w_count), 32'd0);
        check_val("rst_done", 32'(w_done), 32'd0);
        for (int i = 1; i <= 4; i++) load_op(32'(i));
        start_op();
        sig0 = n_sig; nf = 0; ns = 0;
        h[0] = 0; h[1] = 0; acc[0] = '0; acc[1] = '0;
        for (int it = 0; it < 40; it++) begin
            if (sb_q.size() == 1 && h[0] == 0 && h[1] == 0) break;
            p = it % 2; q = 1 - p;
            if (h[p] == 2) begin
                txn(p, OP_SEND, acc[p], v); h[p] = 0; ns++;
            end else if (h[p] == 1 && sb_q.size() >= 1) begin
                txn(p, OP_FETCH, '0, v); acc[p] = acc[p] + v; h[p] = 2; nf++;
            end else if (h[p] == 0 && sb_q.size() >= 2 + ((h[q] == 1) ? 1 : 0)) begin
                txn(p, OP_FETCH, '0, v); acc[p] = v; h[p] = 1; nf++;
            end
        end
        repeat (3) @(negedge clk);
        check_val("t1_done", 32'(w_done), 32'd1);
        check_val("t1_result", w_result, 32'd10);
        check_val("t1_count", 32'(w_count), 32'd1);
        check_val("t1_busy", 32'(w_busy), 32'd0);
        check_val("t1_held", 32'(dut2.r_held), 32'd0);
        check_val("t1_fetches", 32'(nf), 32'd6);
        check_val("t1_sends", 32'(ns), 32'd3);
        check_val("t1_strobes", 32'(n_sig - sig0), 32'd9);

        // 2: all four requesting, round-robin order 0,1,2,3,0
        sel2 = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) load_op(32'h100 + 32'(i));
        start_op();
        req = 4'hF;
        for (int t = 0; t < 5; t++) begin
            int n = 0;
            do begin @(negedge clk); n++; end while (w_grant == '0 && n < 20);
            p = t % 4;
            check_val("t2_grant_order", 32'(w_grant), 32'(4'b0001 << p));
            op = OP_FETCH;
            @(negedge clk);
            check_val("t2_signal", 32'(w_sig), 32'd1);
            v = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
            check_val("t2_read", w_read, v);
            op = OP_NOP; req[p] = 1'b0;
            @(negedge clk);
            check_val("t2_gap_grant", 32'(w_grant), 32'd0);
            @(negedge clk);
            req[p] = 1'b1;
        end
        req = '0;

        // 3: single FETCH
        do_reset();
        load_op(32'hA5A5_0001); load_op(32'hA5A5_0002); load_op(32'hA5A5_0003);
        start_op();
        check_val("t3_count_before", 32'(w_count), 32'd3);
        txn(0, OP_FETCH, '0, v);
        check_val("t3_count_after", 32'(w_count), 32'd2);

        // 4: FETCH on empty pool starves; grant stays on P0
        do_reset();
        load_op(32'd7); load_op(32'd9);
        start_op();
        txn(0, OP_FETCH, '0, v);
        txn(1, OP_FETCH, '0, v);
        @(negedge clk);
        req[0] = 1'b1;
        wait_grant(0);
        check_val("t4_grant", 32'(w_grant), 32'd1);
        sig0 = n_sig;
        op = OP_FETCH;
        repeat (STALL_MAX) @(negedge clk);
        check_val("t4_not_yet_starved", 32'(w_starved), 32'd0);
        @(negedge clk);
        check_val("t4_starved", 32'(w_starved), 32'd1);
        check_val("t4_grant_held", 32'(w_grant), 32'd1);
        check_val("t4_no_signal", 32'(n_sig - sig0), 32'd0);
        op = OP_NOP; req = '0;

        // 5: async reset during SIG
        do_reset();
        load_op(32'd11); load_op(32'd12); load_op(32'd13);
        start_op();
        req[0] = 1'b1;
        wait_grant(0);
        op = OP_FETCH;
        @(negedge clk);
        check_val("t5_in_sig", 32'(w_sig), 32'd1);
        reset = 1'b1;
        #1;
        check_val("t5_grant", 32'(w_grant), 32'd0);
        check_val("t5_signal", 32'(w_sig), 32'd0);
        check_val("t5_count", 32'(w_count), 32'd0);
        check_val("t5_done", 32'(w_done), 32'd0);
        @(negedge clk);

        // 6: overfill and loads while busy
        do_reset();
        for (int i = 0; i <= DEPTH; i++) begin
            check_val("t6_load_ready", 32'(w_lr), (i < DEPTH) ? 32'd1 : 32'd0);
            load_op(32'd100 + 32'(i));
        end
        check_val("t6_count_full", 32'(w_count), 32'd16);
        start_op();
        check_val("t6_busy", 32'(w_busy), 32'd1);
        txn(0, OP_FETCH, '0, v);
        check_val("t6_count_after_fetch", 32'(w_count), 32'd15);
        check_val("t6_ready_busy", 32'(w_lr), 32'd0);
        load_op(32'd777);
        check_val("t6_busy_load_ignored", 32'(w_count), 32'd15);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
